io_port: RTL
============

# io_port

Peripheral-side I/O port for the 18-bit accumulator processor. Its processor side is the input register (INPR) and output register (OUTR), with their input-ready and output-empty flags. Its device side is a pair of valid/ready streams. The block buffers device input in a small FIFO and serialises processor output words to the device. It also generates the gated interrupt request that the control block samples.

## Interface

Parameters:
- `DATA_W`, 18, width of every data word.
- `IN_DEPTH`, 4, input FIFO depth; must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inpr_read`  in  1  processor pops the INPR head this cycle.
- `inpr_data`  out  DATA_W  current FIFO head; 0 when empty.
- `outr_write`  in  1  processor loads OUTR this cycle.
- `outr_data`  in  DATA_W  word to load into OUTR.
- `flg_i`  out  1  input ready (FIFO non-empty).
- `flg_o`  out  1  output ready (OUTR empty).
- `glob_ie`, `en_i`, `en_o`  in  1 each  global, input and output interrupt enables.
- `irq`  out  1  registered interrupt request.
- `dev_in_valid`  in  1  device offers `dev_in_data`.
- `dev_in_data`  in  DATA_W  device input word.
- `dev_in_ready`  out  1  FIFO not full.
- `dev_out_valid`  out  1  OUTR word offered to the device.
- `dev_out_data`  out  DATA_W  OUTR contents.
- `dev_out_ready`  in  1  device accepts the offered word.
- `ovr_err`  out  1  sticky: `outr_write` arrived while OUTR was full.
- `udr_err`  out  1  sticky: `inpr_read` arrived while the FIFO was empty.

## Operation

Input path (FIFO):
- A device word is pushed when `dev_in_valid & dev_in_ready`.
- The head is popped when `inpr_read & flg_i`.
- Push and pop may occur in the same cycle when the FIFO is neither empty nor full. The count is then unchanged and the order is preserved.
- When the FIFO is full, `dev_in_ready`=0. A pop in that cycle does not enable a push until the next cycle, because ready is combinational from the registered count only.
- Pointers are log2(IN_DEPTH) bits and wrap modulo IN_DEPTH. The count is log2(IN_DEPTH)+1 bits.
- `inpr_read` while the FIFO is empty sets `udr_err` and leaves the state unchanged.

Output path, FSM `O_IDLE` / `O_SEND`:
- `O_IDLE` (`flg_o`=1, `dev_out_valid`=0): on `outr_write`, latch `outr_data` into OUTR and go to `O_SEND`.
- `O_SEND` (`flg_o`=0, `dev_out_valid`=1): `dev_out_data` holds stable. On `dev_out_ready`, go to `O_IDLE`.
- `outr_write` in `O_SEND` sets `ovr_err`; the new word is dropped and OUTR is unchanged. This includes the cycle in which `dev_out_ready`=1: the flag is registered, so the processor must see `flg_o`=1 before writing.

Interrupt:
- `irq` is registered as `glob_ie & ((en_i & flg_i) | (en_o & flg_o))`, evaluated on the current-cycle flags.

Error flags:
- `ovr_err` and `udr_err` clear only on reset.

## Timing

Reset (`rst`=0, asynchronous):
- FIFO is emptied, OUTR=0, FSM=`O_IDLE`.
- Outputs: `flg_i`=0, `flg_o`=1, `dev_in_ready`=1, `dev_out_valid`=0, `dev_out_data`=0, `inpr_data`=0, `irq`=0, `ovr_err`=0, `udr_err`=0.
- Reset asserted mid-transfer abandons the word in OUTR and all FIFO contents.
- Release of reset is synchronised externally; the block acts from the first rising edge after `rst`=1.

Latencies:
- Device push to `flg_i`=1: 1 cycle. Push to `inpr_data` valid: 1 cycle, when the FIFO was empty.
- `inpr_read` to next head on `inpr_data`: 1 cycle.
- `outr_write` to `dev_out_valid`=1 and `flg_o`=0: 1 cycle.
- `dev_out_ready` handshake to `flg_o`=1: 1 cycle.
- Flag change to `irq`: 1 further cycle.

Back-to-back output throughput: one word every 2 cycles minimum (write, then handshake).

## Test plan

1. Reset, then check idle values: `flg_o`=1, `flg_i`=0, `dev_in_ready`=1, `irq`=0, all errors 0. Assert `rst`=0 mid-`O_SEND` → `dev_out_valid` drops immediately, without waiting for a clock edge.
2. Push 0x00001, 0x3FFFF, 0x15555, 0x2AAAA, then attempt a 5th push → `dev_in_ready`=0 after the 4th push and the 5th word is not stored. Four `inpr_read` cycles return the words in order; then `flg_i`=0 and `inpr_data`=0.
3. FIFO holding 2 words; push 0x00123 and pop in the same cycle → count stays 2, and the next two reads return the old second word, then 0x00123. Run 10 push/pop cycles to exercise pointer wrap.
4. `outr_write` 0x2BEEF with `dev_out_ready`=0 for 3 cycles → `dev_out_valid`=1 and `dev_out_data`=0x2BEEF held stable. Assert ready → `flg_o`=1 on the next cycle.
5. `outr_write` during `O_SEND` → `ovr_err`=1 and stays 1, and the device receives only the first word. `inpr_read` with the FIFO empty → `udr_err`=1.
6. With `glob_ie`=1 and `en_o`=1 at idle → `irq`=1 one cycle later. Clear `en_o` → `irq`=0 next cycle. With `en_i`=1 and a single push → `irq` rises 2 cycles after the push.

Source files
------------

// File: rtl/io_port.sv
// io_port: processor-facing INPR/OUTR port with a device-side input FIFO,
// a two-state output serialiser, sticky error flags and a registered IRQ.
module io_port #(
  parameter int DATA_W   = 18,
  parameter int IN_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  // processor side
  input  logic              inpr_read,
  output logic [DATA_W-1:0] inpr_data,
  input  logic              outr_write,
  input  logic [DATA_W-1:0] outr_data,
  output logic              flg_i,
  output logic              flg_o,
  input  logic              glob_ie,
  input  logic              en_i,
  input  logic              en_o,
  output logic              irq,
  // device side
  input  logic              dev_in_valid,
  input  logic [DATA_W-1:0] dev_in_data,
  output logic              dev_in_ready,
  output logic              dev_out_valid,
  output logic [DATA_W-1:0] dev_out_data,
  input  logic              dev_out_ready,
  // sticky errors
  output logic              ovr_err,
  output logic              udr_err
);

  localparam int PTR_W = $clog2(IN_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_SEND = 1'b1
  } out_state_t;

  logic [DATA_W-1:0] mem [IN_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  out_state_t        state;
  logic [DATA_W-1:0] outr;

  // Flags and handshakes decode directly from registered state, so a
  // pop while full frees a slot only from the following cycle.
  assign flg_i         = (count != '0);
  assign dev_in_ready  = (count != CNT_W'(IN_DEPTH));
  assign push          = dev_in_valid & dev_in_ready;
  assign pop           = inpr_read & flg_i;
  assign inpr_data     = flg_i ? mem[rd_ptr] : '0;

  assign flg_o         = (state == O_IDLE);
  assign dev_out_valid = (state == O_SEND);
  assign dev_out_data  = outr;

  // FIFO storage: data only, validity is tracked by count and pointers.
  // NOTE: the storage array has no reset; entries are never observed
  // before being written because inpr_data is forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dev_in_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  // NOTE: all sequential state uses non-blocking assignment so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output serialiser: latch a word in idle, hold it until the device takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= O_IDLE;
      outr  <= '0;
    end else begin
      case (state)
        O_IDLE: begin
          if (outr_write) begin
            outr  <= outr_data;
            state <= O_SEND;
          end
        end
        O_SEND: begin
          if (dev_out_ready) begin
            state <= O_IDLE;
          end
        end
        default: state <= O_IDLE;
      endcase
    end
  end

  // Sticky protocol errors: write while OUTR is full, read while INPR is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_err <= 1'b0;
      udr_err <= 1'b0;
    end else begin
      if (outr_write && state == O_SEND) ovr_err <= 1'b1;
      if (inpr_read && !flg_i)           udr_err <= 1'b1;
    end
  end

  // Gated interrupt request, registered from the current-cycle flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= glob_ie & ((en_i & flg_i) | (en_o & flg_o));
    end
  end

endmodule
